// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, default oversample ratio
// and the parity helper used by both the receiver and the transmitter.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BREAK
  } uart_rx_state_t;

  localparam int UART_OVERSAMPLE = 16;
  localparam int UART_MAX_BITS   = 9;

  // Expected parity bit; callers zero-extend narrower words, which leaves the XOR unchanged.
  function automatic logic uart_parity(input logic [UART_MAX_BITS-1:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level; both stages reset to RESET_VAL.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: oversampled start/data/parity/stop deserialiser feeding a
// valid/ready holding register with parity, framing and overrun status.
module uart_rx
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int OVERSAMPLE = UART_OVERSAMPLE
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 RX_tick,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun
);

  localparam int SCNT_W = $clog2(OVERSAMPLE);
  localparam int BCNT_W = 4;
  localparam logic [SCNT_W-1:0] SCNT_HALF = SCNT_W'(OVERSAMPLE / 2 - 1);
  localparam logic [SCNT_W-1:0] SCNT_FULL = SCNT_W'(OVERSAMPLE - 1);
  localparam logic [BCNT_W-1:0] BCNT_LAST = BCNT_W'(DATA_BITS - 1);
  localparam uart_rx_state_t    AFTER_DATA = (PARITY_EN != 0) ? PARITY : STOP;

  logic rx_s;
  logic tick_d1_q;
  logic tick;
  logic mid_bit;
  logic frame_done;

  uart_rx_state_t       state_q, state_d;
  logic [SCNT_W-1:0]    scnt_q, scnt_d;
  logic [BCNT_W-1:0]    bcnt_q, bcnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 perr_q, perr_d;
  logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
  logic                 rx_valid_q, rx_valid_d;
  logic                 parity_err_q, parity_err_d;
  logic                 frame_err_q, frame_err_d;
  logic                 overrun_q, overrun_d;

  sync_2ff #(.RESET_VAL(1'b1)) u_rx_sync (
    .clk   (clk),
    .rst_n (rst),
    .d     (rx),
    .q     (rx_s)
  );

  assign tick    = RX_tick & ~tick_d1_q;
  assign mid_bit = tick && (scnt_q == SCNT_FULL);

  always_comb begin
    state_d      = state_q;
    scnt_d       = scnt_q;
    bcnt_d       = bcnt_q;
    shift_d      = shift_q;
    perr_d       = perr_q;
    rx_data_d    = rx_data_q;
    rx_valid_d   = rx_valid_q;
    parity_err_d = parity_err_q;
    frame_err_d  = frame_err_q;
    overrun_d    = 1'b0;
    frame_done   = 1'b0;

    // Free-running bit-period counter; states that need a fresh phase clear it explicitly.
    if (tick) begin
      scnt_d = (scnt_q == SCNT_FULL) ? '0 : scnt_q + SCNT_W'(1);
    end

    case (state_q)
      IDLE: begin
        if (tick && !rx_s) begin
          scnt_d  = '0;
          state_d = START;
        end
      end
      START: begin
        if (tick && (scnt_q == SCNT_HALF)) begin
          scnt_d  = '0;
          bcnt_d  = '0;
          perr_d  = 1'b0;
          state_d = rx_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (mid_bit) begin
          shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
          bcnt_d  = bcnt_q + BCNT_W'(1);
          if (bcnt_q == BCNT_LAST) state_d = AFTER_DATA;
        end
      end
      PARITY: begin
        if (mid_bit) begin
          perr_d  = rx_s ^ uart_parity(UART_MAX_BITS'(shift_q), 1'(PARITY_ODD));
          state_d = STOP;
        end
      end
      STOP: begin
        if (mid_bit) begin
          frame_done = 1'b1;
          state_d    = rx_s ? IDLE : BREAK;
        end
      end
      BREAK: begin
        if (rx_s) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (rx_valid_q && rx_ready) rx_valid_d = 1'b0;

    // A completing frame may overwrite only a register that is empty or being drained now.
    if (frame_done) begin
      if (!rx_valid_q || rx_ready) begin
        rx_data_d    = shift_q;
        parity_err_d = perr_q;
        frame_err_d  = ~rx_s;
        rx_valid_d   = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tick_d1_q    <= 1'b0;
      state_q      <= IDLE;
      scnt_q       <= '0;
      bcnt_q       <= '0;
      shift_q      <= '0;
      perr_q       <= 1'b0;
      rx_data_q    <= '0;
      rx_valid_q   <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      tick_d1_q    <= RX_tick;
      state_q      <= state_d;
      scnt_q       <= scnt_d;
      bcnt_q       <= bcnt_d;
      shift_q      <= shift_d;
      perr_q       <= perr_d;
      rx_data_q    <= rx_data_d;
      rx_valid_q   <= rx_valid_d;
      parity_err_q <= parity_err_d;
      frame_err_q  <= frame_err_d;
      overrun_q    <= overrun_d;
    end
  end

  assign rx_data    = rx_data_q;
  assign rx_valid   = rx_valid_q;
  assign parity_err = parity_err_q;
  assign frame_err  = frame_err_q;
  assign overrun    = overrun_q;

endmodule
